// File: rtl/bottling_pkg.sv
// Shared definitions for the bottling controller: state encoding and default widths.
package bottling_pkg;

  localparam int PILL_W_DEF   = 6;
  localparam int BOTTLE_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SWAP = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/bottling_controller.sv
// Bottling line controller: counts pills into bottles and bottles into a batch.
// Optional feature macro: BOTTLING_PAUSE_EN (pause level freezes FILL/SWAP).
// The pill/flicker divider lives outside this block.
module bottling_controller
  import bottling_pkg::*;
#(
  parameter int PILL_W   = PILL_W_DEF,
  parameter int BOTTLE_W = BOTTLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                pill_pulse,
  input  logic                display_flicker,
  input  logic [PILL_W-1:0]   pills_per_bottle,
  input  logic [BOTTLE_W-1:0] bottle_target,
  output logic [PILL_W-1:0]   pill_count,
  output logic [BOTTLE_W-1:0] bottle_count,
  output logic                valve_open,
  output logic                conveyor_on,
  output logic                done,
  output logic                cfg_error,
  output logic                display_blink,
  output logic [1:0]          state
);

  state_e              state_q, state_d;
  logic [PILL_W-1:0]   pill_q, pill_d, ppb_q, ppb_d;
  logic [BOTTLE_W-1:0] bottle_q, bottle_d, tgt_q, tgt_d;
  logic                cfg_err_q, cfg_err_d;
  logic                paused;
  logic                cfg_ok;
  logic [PILL_W-1:0]   pill_inc;
  logic [BOTTLE_W-1:0] bottle_inc;

`ifdef BOTTLING_PAUSE_EN
  assign paused = pause && (state_q == FILL || state_q == SWAP);
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign paused       = 1'b0;
`endif

  assign cfg_ok     = (pills_per_bottle != '0) && (bottle_target != '0);
  // Counts cannot wrap: FILL leaves as soon as pill_inc reaches the nonzero latched setting.
  assign pill_inc   = pill_q + 1'b1;
  assign bottle_inc = bottle_q + 1'b1;

  // Next-state and datapath update; stop beats pause beats start/pill_pulse.
  always_comb begin
    state_d   = state_q;
    pill_d    = pill_q;
    bottle_d  = bottle_q;
    ppb_d     = ppb_q;
    tgt_d     = tgt_q;
    cfg_err_d = cfg_err_q;
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
    end else if (!paused) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (cfg_ok) begin
              state_d   = FILL;
              ppb_d     = pills_per_bottle;
              tgt_d     = bottle_target;
              pill_d    = '0;
              bottle_d  = '0;
              cfg_err_d = 1'b0;
            end else begin
              state_d   = IDLE;
              cfg_err_d = 1'b1;
            end
          end
        end
        FILL: begin
          if (pill_pulse) begin
            pill_d = pill_inc;
            if (pill_inc == ppb_q) begin
              bottle_d = bottle_inc;
              state_d  = (bottle_inc == tgt_q) ? DONE : SWAP;
            end
          end
        end
        SWAP: begin
          // The pill arriving during the swap is lost; it only marks the new bottle in place.
          if (pill_pulse) begin
            pill_d  = '0;
            state_d = FILL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters, latched settings and config-error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pill_q    <= '0;
      bottle_q  <= '0;
      ppb_q     <= '0;
      tgt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pill_q    <= pill_d;
      bottle_q  <= bottle_d;
      ppb_q     <= ppb_d;
      tgt_q     <= tgt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign pill_count    = pill_q;
  assign bottle_count  = bottle_q;
  assign cfg_error     = cfg_err_q;
  assign state         = state_q;
  assign valve_open    = (state_q == FILL) && !paused;
  assign conveyor_on   = (state_q == SWAP) && !paused;
  assign done          = (state_q == DONE);
  assign display_blink = display_flicker && ((state_q == DONE) || paused || cfg_err_q);

endmodule

// File: tb/tb_bottling_controller.sv
// Directed table-driven bench for bottling_controller, plus a reset-in-SWAP sequence.
module tb_bottling_controller;

`ifdef BOTTLING_PAUSE_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, stop, pause, pill_pulse, display_flicker;
  logic [5:0] pills_per_bottle, pill_count;
  logic [7:0] bottle_target, bottle_count;
  logic       valve_open, conveyor_on, done, cfg_error, display_blink;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bottling_controller dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .pill_pulse(pill_pulse), .display_flicker(display_flicker),
    .pills_per_bottle(pills_per_bottle), .bottle_target(bottle_target),
    .pill_count(pill_count), .bottle_count(bottle_count),
    .valve_open(valve_open), .conveyor_on(conveyor_on), .done(done),
    .cfg_error(cfg_error), .display_blink(display_blink), .state(state)
  );

  typedef struct {
    logic rst, st, sp, pa, pp, fl;
    logic [5:0] ppb;
    logic [7:0] tgt;
    logic [20:0] exp;  // {pc, bc, state, valve, conv, done, cfg, blink}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, st, sp, pa, pp, fl,
                              input logic [5:0] ppb, input logic [7:0] tgt,
                              input logic [5:0] pc, input logic [7:0] bc,
                              input logic [1:0] s,
                              input logic va, cv, dn, cf, bl);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.pa = pa; v.pp = pp; v.fl = fl;
    v.ppb = ppb; v.tgt = tgt;
    v.exp = {pc, bc, s, va, cv, dn, cf, bl};
    return v;
  endfunction

  function automatic logic [20:0] outs();
    return {pill_count, bottle_count, state, valve_open, conveyor_on, done,
            cfg_error, display_blink};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got pc=%0d bc=%0d st=%0d v/c/d/e/b=%b want pc=%0d bc=%0d st=%0d v/c/d/e/b=%b",
               name, act[20:15], act[14:7], act[6:5], act[4:0],
               exp[20:15], exp[14:7], exp[6:5], exp[4:0]);
    end
  endtask

  task automatic drive(input logic rst, st, sp, pa, pp, fl,
                       input logic [5:0] ppb, input logic [7:0] tgt);
    @(negedge clk);
    reset = rst; start = st; stop = sp; pause = pa; pill_pulse = pp;
    display_flicker = fl; pills_per_bottle = ppb; bottle_target = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; pill_pulse = 1'b0;
    display_flicker = 1'b0; pills_per_bottle = '0; bottle_target = '0;

    //             rst st sp pa pp fl ppb tgt   pc bc st va cv dn cf bl
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 2,   0, 0, 0, 0, 0, 0, 0, 0)); // 0 reset
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 3, 2,   0, 0, 1, 1, 0, 0, 0, 0)); // 1 start
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 2,   1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 2,   1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 2,   2, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 2,   3, 1, 2, 0, 1, 0, 0, 0)); // 5 full -> SWAP
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 2,   3, 1, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 2,   0, 1, 1, 1, 0, 0, 0, 0)); // 7 discarded pulse
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 2,   1, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 2,   2, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 3, 2,   3, 2, 3, 0, 0, 1, 0, 1)); // 10 DONE
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 2,   3, 2, 3, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 2,   3, 2, 0, 0, 0, 0, 1, 1)); // 12 bad cfg
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2,   3, 2, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 3, 2,   0, 0, 1, 1, 0, 0, 0, 0)); // 14 valid start
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1,   1, 0, 1, 1, 0, 0, 0, 0)); // 15 start ignored
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1,   2, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 3, 2,   2, 0, 0, 0, 0, 0, 0, 0)); // 17 stop+pill
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 2,   2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 2,   2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1,   0, 0, 1, 1, 0, 0, 0, 0)); // 20 1x1 batch
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1,   1, 1, 3, 0, 0, 1, 0, 0)); // 21 straight to DONE
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 9,   0, 0, 1, 1, 0, 0, 0, 0)); // 22 restart from DONE
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 9, 9,   1, 0, 1, 1, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)                                            // 24..27 pause
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 9, 9, PE ? 6'd1 : 6'(2 + k), 0, 1,
                       !PE, 0, 0, 0, PE));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 9, 9, PE ? 6'd2 : 6'd6, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 9, 9, PE ? 6'd2 : 6'd6, 0, 0, 0, 0, 0, 0, 0)); // stop>pause

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].pp, tbl[i].fl,
            tbl[i].ppb, tbl[i].tgt);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Reset while in SWAP after five completed bottles.
    drive(0, 1, 0, 0, 0, 0, 1, 9);
    for (int b = 1; b <= 5; b++) begin
      drive(0, 0, 0, 0, 1, 0, 1, 9);
      check($sformatf("swap_bottle%0d", b), outs(),
            {6'd1, 8'(b), 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      if (b < 5) drive(0, 0, 0, 0, 1, 0, 1, 9);
    end
    drive(1, 1, 1, 1, 1, 1, 1, 9);
    check("reset_in_swap", outs(), 21'd0);
    drive(0, 0, 0, 0, 1, 1, 1, 9);
    check("idle_after_reset", outs(), 21'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
